// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side logic: data width, FIFO depth
// and the reader FSM state encoding.
package fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_RUN  = 2'd1,
        RD_STOP = 2'd2
    } rd_state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Bundles the FIFO read port and the valid/ready output stream of the reader.
// master = the reader engine, slave = the FIFO/consumer side.
interface fifo_reader_if;
    import fifo_pkg::*;

    logic              ren;
    logic              empty;
    logic [DATA_W-1:0] rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output ren, out_valid, out_data,
        input  empty, rdata, out_ready
    );

    modport slave (
        input  ren, out_valid, out_data,
        output empty, rdata, out_ready
    );

endinterface

// File: rtl/byte_buf2.sv
// Two-entry in-order byte queue; push and pop may coincide at any occupancy.
// The head entry is always presented on dout.
module byte_buf2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        occ
);
    import fifo_pkg::*;

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;

    // NOTE: the two storage entries are reset as well, so the head reads 0
    // after reset instead of whatever the flops powered up with.
    // NOTE: non-blocking assignments here so every entry update sees the
    // pre-edge values of head/tail/occ, whatever order the lines are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head <= din;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head <= din;
                        2'b10: begin
                            tail <= din;
                            occ  <= 2'd2;
                        end
                        2'b01: occ <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // The upstream credit check never pushes into a full queue without a pop.
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= din;
                        else      occ  <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    assign dout = head;

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine: pops the FIFO under a credit check, absorbs the FIFO's
// one-cycle read latency and streams the bytes out over valid/ready.
module fifo_reader #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    fifo_reader_if.master bus,
    output logic          busy,
    output logic [15:0]   byte_count
);
    import fifo_pkg::*;

    rd_state_e         state;
    rd_state_e         state_next;
    logic              inflight;
    logic              pop;
    logic              room;
    logic              ren_c;
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf_dout;

    assign pop = bus.out_valid & bus.out_ready;

    // Bytes already owed to the buffer (held + in flight) minus the one
    // leaving this cycle must stay below the buffer depth before popping again.
    assign room = (({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop}) < 3'(BUF_DEPTH);

    byte_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   (bus.rdata),
        .pop   (pop),
        .dout  (buf_dout),
        .occ   (occ)
    );

    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = buf_dout;
    assign bus.ren       = ren_c;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        ren_c      = 1'b0;
        case (state)
            RD_IDLE: begin
                if (enable) state_next = RD_RUN;
                ren_c = enable && !bus.empty && room;
            end
            RD_RUN: begin
                if (!enable) state_next = RD_STOP;
                ren_c = enable && !bus.empty && room;
            end
            RD_STOP: begin
                if (enable)                             state_next = RD_RUN;
                else if (occ == 2'd0 && !inflight)      state_next = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RD_IDLE;
            inflight   <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
        end else begin
            state    <= state_next;
            inflight <= ren_c;
            busy     <= (state_next != RD_IDLE);
            if (pop) byte_count <= byte_count + 16'd1;
        end
    end

endmodule
